uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receive path, paired with the design's UART transmitter on the same link.
- Frame format is 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); idle line is high.
- Samples the line on a 16x oversampling tick `enb` from the shared baud generator.
- Presents each received byte with a ready flag held until software/host clears it.
- Also reports framing error and overrun.

Parameters:
- OVS, 16, oversampling ticks per bit; power of two, >= 8. Counter width is log2(OVS).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx  input  1  serial line, asynchronous to clk
- enb  input  1  oversample tick; one-clk pulse, OVS pulses per bit period
- rdy_clr  input  1  one-clk pulse; clears rdy and overrun
- data_out  output  8  last received byte
- rdy  output  1  byte available (sticky)
- frame_err  output  1  last frame had stop bit = 0
- overrun  output  1  byte completed while rdy already set (sticky)
- busy  output  1  frame reception in progress (state != IDLE)

Behaviour:
- Interface: clock clk; reset reset, asynchronous, active-high.
- Reset values:
  - data_out = 0x00; rdy = 0; frame_err = 0; overrun = 0; busy = 0.
  - state = IDLE; tick counter = 0; bit index = 0; shift register = 0.
  - Synchronizer flops = 1 (line idle).
  - Reset mid-frame aborts the frame with no partial output.
- rx passes through a 2-FF synchronizer (reset value 1). All logic uses the synchronized value rx_s, which is 2 clk behind rx.
- Counter advance: the tick counter advances only on clk edges with enb = 1. With enb = 0, all state holds.
- State machine (2-bit encoding):
  - IDLE:
    - On enb with rx_s = 0: go to START, counter = 0.
    - Otherwise stay. busy = 0.
  - START:
    - Count enb ticks. At the tick where counter = OVS/2-1 (mid start bit), sample rx_s.
    - rx_s = 0: go to DATA, counter = 0, index = 0.
    - rx_s = 1: false start (glitch); return to IDLE, no flags changed.
  - DATA:
    - At the tick where counter = OVS-1 (mid data bit), shift rx_s into the MSB of the shift register (LSB-first reconstruction), counter = 0.
    - index = 7 at that sample: go to STOP, index = 0. Otherwise index + 1.
  - STOP:
    - At the tick where counter = OVS-1, sample rx_s and return to IDLE.
    - rx_s = 1:
      - data_out <= shift register; frame_err <= 0.
      - rdy <= 1.
      - If rdy was already 1 and rdy_clr is not asserted this cycle: overrun <= 1.
    - rx_s = 0:
      - frame_err <= 1.
      - data_out, rdy and overrun are unchanged; the byte is discarded.
  - Illegal state: go to IDLE.
- Latency:
  - rdy rises on the clk edge of the enb tick that samples mid stop bit.
  - Nominal timing is 9.5 bit periods + 2 clk after the rx falling edge.
- rdy_clr:
  - Clears rdy and overrun on the next edge.
  - If a valid stop sample lands in the same cycle: completion wins. rdy = 1, new data_out is loaded, overrun = 0.
- A new start bit is accepted from IDLE immediately after STOP; there is no inter-frame gap requirement.
- busy = 1 in START/DATA/STOP, registered together with the state.
- rx held low (break): frame ends with frame_err = 1. The receiver then re-enters START on the next tick while the line stays low, and keeps flagging frame_err per frame until the line returns high.

Test Plan:
- Single byte: enb every 4 clk (OVS=16), rx sends 0xA5 8N1 at 64 clk/bit.
  - Required: data_out = 0xA5, rdy = 1, frame_err = 0, overrun = 0.
  - rdy rises within 9.5 bit periods + 2 clk ±1 tick of the start edge.
  - busy is high throughout the frame.
- Back-to-back: send 0x00, then 0xFF, with no rdy_clr between them.
  - Required: data_out = 0xFF, rdy = 1, overrun = 1.
  - Then pulse rdy_clr. Required: rdy = 0, overrun = 0.
- Glitch: rx low for 3 ticks, then high.
  - Required: START aborts at the mid-bit check, state returns to IDLE.
  - busy pulses only for the glitch; rdy and frame_err stay 0.
- Framing error: send 0x3C with stop bit = 0.
  - Required: frame_err = 1, rdy = 0, data_out keeps its previous value.
  - A following good 0x3C gives frame_err = 0, rdy = 1, data_out = 0x3C.
- Collision: assert rdy_clr on the exact clk of the stop sample while rdy = 1.
  - Required: rdy = 1, overrun = 0, data_out = new byte.
- Reset mid-frame: assert reset during bit 4 of 0x5A.
  - Required: all outputs at reset values immediately.
  - After reset releases, a subsequent 0x81 is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receive path: 8N1 frames sampled on a 16x (OVS) oversampling tick.
// Recovers one byte per frame, holds it with a sticky ready flag until the
// host clears it, and reports framing errors and overruns.
module uart_receiver #(
   parameter int OVS = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       enb,
   input  logic       rdy_clr,
   output logic [7:0] data_out,
   output logic       rdy,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CW = $clog2(OVS);
   localparam logic [CW-1:0] HALF_M1 = CW'(OVS / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(OVS - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   logic          rx_meta;
   logic          rx_s;
   state_t        state,     state_n;
   logic [CW-1:0] cnt,       cnt_n;
   logic [2:0]    idx,       idx_n;
   logic [7:0]    shreg,     shreg_n;
   logic [7:0]    data_n;
   logic          rdy_n;
   logic          frame_err_n;
   logic          overrun_n;
   logic          busy_n;

   // Two-flop synchronizer for the asynchronous serial line; idles high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Next-state and output decode; everything advances only on an enb tick
   // except the host clear, which acts on any cycle.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      idx_n       = idx;
      shreg_n     = shreg;
      data_n      = data_out;
      frame_err_n = frame_err;
      rdy_n       = rdy;
      overrun_n   = overrun;

      if (rdy_clr) begin
         rdy_n     = 1'b0;
         overrun_n = 1'b0;
      end else begin
         rdy_n     = rdy;
         overrun_n = overrun;
      end

      if (enb) begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_n = START;
                  cnt_n   = '0;
               end else begin
                  state_n = IDLE;
               end
            end
            START: begin
               if (cnt == HALF_M1) begin
                  // Mid start bit: a high line here means it was a glitch.
                  if (!rx_s) begin
                     state_n = DATA;
                     cnt_n   = '0;
                     idx_n   = 3'd0;
                  end else begin
                     state_n = IDLE;
                     cnt_n   = '0;
                  end
               end else begin
                  cnt_n = cnt + CNT_ONE;
               end
            end
            DATA: begin
               if (cnt == FULL_M1) begin
                  // LSB arrives first, so shift in from the top.
                  shreg_n = {rx_s, shreg[7:1]};
                  cnt_n   = '0;
                  if (idx == 3'd7) begin
                     state_n = STOP;
                     idx_n   = 3'd0;
                  end else begin
                     idx_n = idx + 3'd1;
                  end
               end else begin
                  cnt_n = cnt + CNT_ONE;
               end
            end
            STOP: begin
               if (cnt == FULL_M1) begin
                  state_n = IDLE;
                  cnt_n   = '0;
                  if (rx_s) begin
                     // Completion takes priority over a same-cycle clear.
                     data_n      = shreg;
                     frame_err_n = 1'b0;
                     rdy_n       = 1'b1;
                     if (rdy_clr) begin
                        overrun_n = 1'b0;
                     end else if (rdy) begin
                        overrun_n = 1'b1;
                     end else begin
                        overrun_n = overrun;
                     end
                  end else begin
                     frame_err_n = 1'b1;
                  end
               end else begin
                  cnt_n = cnt + CNT_ONE;
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
               idx_n   = 3'd0;
            end
         endcase
      end else begin
         state_n = state;
      end

      busy_n = (state_n != IDLE);
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= 3'd0;
         shreg     <= 8'h00;
         data_out  <= 8'h00;
         rdy       <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         shreg     <= shreg_n;
         data_out  <= data_n;
         rdy       <= rdy_n;
         frame_err <= frame_err_n;
         overrun   <= overrun_n;
         busy      <= busy_n;
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: 64 clk per bit, enb every 4 clk.
module tb_uart_receiver;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       enb = 1'b0;
   logic       rdy_clr = 1'b0;
   logic [7:0] data_out;
   logic       rdy;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int total = 0;
   int bad = 0;
   int ph = 0;

   // Reference model of the host-visible receiver registers.
   logic [7:0] m_data = 8'h00;
   logic       m_rdy = 1'b0;
   logic       m_fe = 1'b0;
   logic       m_ovr = 1'b0;

   uart_receiver #(.OVS(16)) dut (
      .clk(clk), .reset(reset), .rx(rx), .enb(enb), .rdy_clr(rdy_clr),
      .data_out(data_out), .rdy(rdy), .frame_err(frame_err),
      .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   // Oversample tick: one clk high out of every four.
   always @(negedge clk) begin
      ph = (ph + 1) % 4;
      enb = (ph == 0);
   end

   task automatic model_frame(input logic [7:0] b, input logic stop_b, input logic clr);
      if (stop_b) begin
         if (clr) m_ovr = 1'b0;
         else if (m_rdy) m_ovr = 1'b1;
         m_rdy  = 1'b1;
         m_data = b;
         m_fe   = 1'b0;
      end else begin
         m_fe = 1'b1;
         if (clr) begin
            m_rdy = 1'b0;
            m_ovr = 1'b0;
         end
      end
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      rdy_clr = 1'b1;
      @(negedge clk);
      rdy_clr = 1'b0;
      m_rdy = 1'b0;
      m_ovr = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Sends one frame aligned just after a sampled tick. Records the first
   // clk (relative to the start edge) where rdy is seen high, and whether
   // busy stayed high through the body of the frame.
   task automatic send_frame(input logic [7:0] b, input logic stop_b,
                             input logic clr_at_stop, input int abort_k,
                             output int rise_k, output logic busy_ok);
      logic [9:0] bits;
      int guard;
      bits = {stop_b, b, 1'b0};
      rise_k = -1;
      busy_ok = 1'b1;
      guard = 0;
      do begin
         @(posedge clk);
         guard++;
      end while (enb !== 1'b1 && guard < 16);
      @(negedge clk);
      rx = bits[0];
      for (int k = 1; k <= 640; k++) begin
         @(negedge clk);
         if (k == abort_k) begin
            reset = 1'b1;
            rx = 1'b1;
            return;
         end
         if (k % 64 == 0) rx = (k == 640) ? 1'b1 : bits[k / 64];
         if (k == 611 && clr_at_stop) rdy_clr = 1'b1;
         if (k == 612) rdy_clr = 1'b0;
         if (rdy === 1'b1 && rise_k < 0) rise_k = k;
         if (k >= 8 && k <= 600 && busy !== 1'b1) busy_ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      total++;
      if ({data_out, rdy, frame_err, overrun, busy} !== 12'h000) begin
         bad++;
         $display("FAIL reset_values: got data=%h rdy=%b fe=%b ovr=%b busy=%b, want all 0",
                  data_out, rdy, frame_err, overrun, busy);
      end
   endtask

   task automatic test_single_byte();
      int rk; logic bok;
      send_frame(8'hA5, 1'b1, 1'b0, 0, rk, bok);
      model_frame(8'hA5, 1'b1, 1'b0);
      total++;
      if (data_out !== 8'hA5 || rdy !== 1'b1 || frame_err !== 1'b0 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL single_byte: got data=%h rdy=%b fe=%b ovr=%b, want a5 1 0 0",
                  data_out, rdy, frame_err, overrun);
      end
      total++;
      if (rk < 606 || rk > 614) begin
         bad++;
         $display("FAIL single_latency: rdy rose at clk %0d, want 606..614", rk);
      end
      total++;
      if (bok !== 1'b1) begin
         bad++;
         $display("FAIL single_busy: busy dropped mid-frame, want held high");
      end
   endtask

   task automatic test_back_to_back();
      int rk; logic bok;
      pulse_clr();
      send_frame(8'h00, 1'b1, 1'b0, 0, rk, bok);
      model_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0, 0, rk, bok);
      model_frame(8'hFF, 1'b1, 1'b0);
      total++;
      if (data_out !== 8'hFF || rdy !== 1'b1 || overrun !== 1'b1) begin
         bad++;
         $display("FAIL back_to_back: got data=%h rdy=%b ovr=%b, want ff 1 1",
                  data_out, rdy, overrun);
      end
      pulse_clr();
      total++;
      if (rdy !== 1'b0 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL rdy_clr: got rdy=%b ovr=%b, want 0 0", rdy, overrun);
      end
   endtask

   task automatic test_glitch();
      logic seen; int guard;
      seen = 1'b0;
      guard = 0;
      do begin
         @(posedge clk);
         guard++;
      end while (enb !== 1'b1 && guard < 16);
      @(negedge clk);
      rx = 1'b0;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         if (k == 12) rx = 1'b1;
         if (busy === 1'b1) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL glitch_busy: seen_high=%b end=%b, want 1 0", seen, busy);
      end
      total++;
      if (rdy !== m_rdy || frame_err !== 1'b0 || data_out !== m_data) begin
         bad++;
         $display("FAIL glitch_flags: got rdy=%b fe=%b data=%h, want %b 0 %h",
                  rdy, frame_err, data_out, m_rdy, m_data);
      end
   endtask

   task automatic test_framing_error();
      int rk; logic bok;
      send_frame(8'h3C, 1'b0, 1'b0, 0, rk, bok);
      model_frame(8'h3C, 1'b0, 1'b0);
      total++;
      if (frame_err !== 1'b1 || rdy !== 1'b0 || data_out !== m_data) begin
         bad++;
         $display("FAIL frame_err: got fe=%b rdy=%b data=%h, want 1 0 %h",
                  frame_err, rdy, data_out, m_data);
      end
      idle(64);
      send_frame(8'h3C, 1'b1, 1'b0, 0, rk, bok);
      model_frame(8'h3C, 1'b1, 1'b0);
      total++;
      if (frame_err !== 1'b0 || rdy !== 1'b1 || data_out !== 8'h3C) begin
         bad++;
         $display("FAIL frame_recover: got fe=%b rdy=%b data=%h, want 0 1 3c",
                  frame_err, rdy, data_out);
      end
   endtask

   task automatic test_collision();
      int rk; logic bok; logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      total++;
      if (rdy !== 1'b1) begin
         bad++;
         $display("FAIL collision_pre: got rdy=%b, want 1", rdy);
      end
      send_frame(b, 1'b1, 1'b1, 0, rk, bok);
      model_frame(b, 1'b1, 1'b1);
      total++;
      if (rdy !== 1'b1 || overrun !== 1'b0 || data_out !== b) begin
         bad++;
         $display("FAIL collision: got rdy=%b ovr=%b data=%h, want 1 0 %h",
                  rdy, overrun, data_out, b);
      end
   endtask

   task automatic test_reset_mid_frame();
      int rk; logic bok;
      send_frame(8'h5A, 1'b1, 1'b0, 64 * 5 + 32, rk, bok);
      #1;
      m_data = 8'h00; m_rdy = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
      total++;
      if ({data_out, rdy, frame_err, overrun, busy} !== 12'h000) begin
         bad++;
         $display("FAIL reset_mid_frame: got data=%h rdy=%b fe=%b ovr=%b busy=%b, want all 0",
                  data_out, rdy, frame_err, overrun, busy);
      end
      @(negedge clk);
      reset = 1'b0;
      idle(8);
      send_frame(8'h81, 1'b1, 1'b0, 0, rk, bok);
      model_frame(8'h81, 1'b1, 1'b0);
      total++;
      if (data_out !== 8'h81 || rdy !== 1'b1 || frame_err !== 1'b0 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL after_reset: got data=%h rdy=%b fe=%b ovr=%b, want 81 1 0 0",
                  data_out, rdy, frame_err, overrun);
      end
   endtask

   task automatic test_random();
      int rk; logic bok; logic [7:0] b; logic st;
      for (int i = 0; i < 8; i++) begin
         b  = 8'($urandom_range(0, 255));
         st = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1) pulse_clr();
         send_frame(b, st, 1'b0, 0, rk, bok);
         model_frame(b, st, 1'b0);
         total++;
         if (data_out !== m_data || rdy !== m_rdy || frame_err !== m_fe || overrun !== m_ovr) begin
            bad++;
            $display("FAIL random_%0d: got data=%h rdy=%b fe=%b ovr=%b, want %h %b %b %b",
                     i, data_out, rdy, frame_err, overrun, m_data, m_rdy, m_fe, m_ovr);
         end
         if (!st) idle(64);
      end
   endtask

   initial begin
      idle(3);
      test_reset();
      @(negedge clk);
      reset = 1'b0;
      idle(8);
      test_glitch();
      test_single_byte();
      test_back_to_back();
      test_framing_error();
      test_collision();
      test_reset_mid_frame();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
